pca9685_motor_sched: RTL and testbench

Round-robin scheduler that shares the single PCA9685 PWM controller among four motor-command requesters. It owns the power-up configuration of the PCA9685 and translates each motor command (direction plus 12-bit duty) into one auto-increment I2C write. That write programs the motor's A, B and EN channels, which feed the L298 bridge inputs. It sits between the motor control logic and a byte-level I2C master.

---
 rtl/pca9685_motor_sched.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_pca9685_motor_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pca9685_motor_sched.sv
// Round-robin scheduler sharing one PCA9685 among four motors; configures MODE1/MODE2 after reset.
// Latency: grant to first tx_valid is 2 cycles; ack/err pulse 1 cycle after the final rsp_valid.
// Backpressure: tx_* held stable until tx_ready; build macro PCA_SCHED_WDOG_EN adds per-motor idle watchdogs.
module pca9685_motor_sched #(
    parameter logic [6:0]        I2C_ADDR    = 7'h40,
    parameter int                MAX_RETRY   = 2,
    parameter int                WDOG_W      = 24,
    parameter logic [WDOG_W-1:0] WDOG_CYCLES = WDOG_W'(10_000_000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [7:0]  cmd_dir,
    input  logic [47:0] cmd_duty,
    output logic [3:0]  ack,
    output logic [3:0]  err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        tx_stop,
    input  logic        tx_ready,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    output logic        busy,
    output logic        init_done,
    output logic [3:0]  wdog_trip
);

    typedef enum logic [2:0] {INIT0, INIT1, IDLE, SEND, WAIT, FINISH} state_t;
    typedef enum logic [1:0] {CH_OFF, CH_ON, CH_PWM} ch_kind_t;

    localparam logic [7:0] ADDR_W     = {I2C_ADDR, 1'b0};
    localparam logic [3:0] LAST_INIT  = 4'd2;
    localparam logic [3:0] LAST_MOTOR = 4'd13;

    // Enable channel: zero duty is fully off, full-scale duty is fully on.
    function automatic ch_kind_t en_kind(input logic [11:0] d);
        if (d == 12'h000) return CH_OFF;
        if (d == 12'hFFF) return CH_ON;
        return CH_PWM;
    endfunction

    // One byte of a channel word ON_L, ON_H, OFF_L, OFF_H (bit 4 of the high byte is full on/off).
    function automatic logic [7:0] chan_byte(input ch_kind_t kind, input logic [1:0] pos,
                                             input logic [11:0] d);
        logic [7:0] b;
        b = 8'h00;
        case (kind)
            CH_ON:   if (pos == 2'd1) b = 8'h10;
            CH_OFF:  if (pos == 2'd3) b = 8'h10;
            default: begin
                if (pos == 2'd2)      b = d[7:0];
                else if (pos == 2'd3) b = {4'h0, d[11:8]};
            end
        endcase
        return b;
    endfunction

    // Byte idx of the 14-byte auto-increment write covering channels 4k..4k+2.
    function automatic logic [7:0] motor_byte(input logic [3:0] idx, input logic [1:0] k,
                                              input logic [1:0] dir, input logic [11:0] d);
        logic [3:0] rel;
        ch_kind_t   ka, kb, ke, kind;
        logic [7:0] b;
        rel = idx - 4'd2;
        case (dir)
            2'b00:   begin ka = CH_OFF; kb = CH_OFF; ke = CH_OFF;     end
            2'b01:   begin ka = CH_ON;  kb = CH_OFF; ke = en_kind(d); end
            2'b10:   begin ka = CH_OFF; kb = CH_ON;  ke = en_kind(d); end
            default: begin ka = CH_ON;  kb = CH_ON;  ke = CH_ON;      end
        endcase
        case (rel[3:2])
            2'd0:    kind = ka;
            2'd1:    kind = kb;
            default: kind = ke;
        endcase
        if (idx == 4'd0)      b = ADDR_W;
        else if (idx == 4'd1) b = 8'h06 + {2'b00, k, 4'h0};
        else                  b = chan_byte(kind, rel[1:0], d);
        return b;
    endfunction

    // MODE1 = 0x20 (auto-increment), MODE2 = 0x04 (totem-pole outputs).
    function automatic logic [7:0] init_byte(input logic second, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = ADDR_W;
            4'd1:    b = second ? 8'h01 : 8'h00;
            default: b = second ? 8'h04 : 8'h20;
        endcase
        return b;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  byte_q, byte_d;
    logic [3:0]  attempt_q, attempt_d;
    logic        wait_q, wait_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        tx_stop_q, tx_stop_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  dir_q, dir_d;
    logic [11:0] duty_q, duty_d;
    logic        forced_q, forced_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  trip_q, trip_d;
    logic        init_done_q, init_done_d;

    logic [3:0]  wdog_req;
    logic [3:0]  force_grant;
    logic [3:0]  pending;
    logic        found;
    logic [1:0]  pick;

    assign pending = req | wdog_req;

    // Round-robin search starting one slot after the last granted motor.
    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        pick  = rr_q;
        cand  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_q + 2'(i);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and output decode for init, grant and byte transfer.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        attempt_d   = attempt_q;
        wait_d      = wait_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = tx_start_q;
        tx_stop_d   = tx_stop_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        dir_d       = dir_q;
        duty_d      = duty_q;
        forced_d    = forced_q;
        init_done_d = init_done_q;
        ack_d       = 4'h0;
        err_d       = 4'h0;
        trip_d      = 4'h0;
        force_grant = 4'h0;
        case (state_q)
            INIT0, INIT1: begin
                if (wait_q) begin
                    if (rsp_valid) begin
                        wait_d = 1'b0;
                        if (rsp_nack) begin
                            byte_d = 4'd0;
                        end else if (byte_q == LAST_INIT) begin
                            byte_d = 4'd0;
                            if (state_q == INIT0) begin
                                state_d = INIT1;
                            end else begin
                                state_d     = IDLE;
                                init_done_d = 1'b1;
                            end
                        end else begin
                            byte_d = byte_q + 4'd1;
                        end
                    end
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = init_byte(state_q == INIT1, byte_q);
                    tx_start_d = (byte_q == 4'd0);
                    tx_stop_d  = (byte_q == LAST_INIT);
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    tx_start_d = 1'b0;
                    tx_stop_d  = 1'b0;
                    wait_d     = 1'b1;
                end
            end
            IDLE: begin
                if (init_done_q && found) begin
                    grant_d   = pick;
                    rr_d      = pick;
                    forced_d  = !req[pick];
                    dir_d     = req[pick] ? cmd_dir[2*pick +: 2] : 2'b00;
                    duty_d    = cmd_duty[12*pick +: 12];
                    byte_d    = 4'd0;
                    attempt_d = 4'd0;
                    state_d   = SEND;
                    force_grant[pick] = !req[pick];
                end
            end
            SEND: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = motor_byte(byte_q, grant_q, dir_q, duty_q);
                    tx_start_d = (byte_q == 4'd0);
                    tx_stop_d  = (byte_q == LAST_MOTOR);
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    tx_start_d = 1'b0;
                    tx_stop_d  = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (rsp_nack) begin
                        byte_d = 4'd0;
                        if (int'(attempt_q) < MAX_RETRY) begin
                            attempt_d = attempt_q + 4'd1;
                            state_d   = SEND;
                        end else begin
                            state_d         = FINISH;
                            ack_d[grant_q]  = !forced_q;
                            err_d[grant_q]  = !forced_q;
                            trip_d[grant_q] = forced_q;
                        end
                    end else if (byte_q == LAST_MOTOR) begin
                        state_d         = FINISH;
                        ack_d[grant_q]  = !forced_q;
                        trip_d[grant_q] = forced_q;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT0;
            byte_q      <= 4'd0;
            attempt_q   <= 4'd0;
            wait_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            tx_stop_q   <= 1'b0;
            grant_q     <= 2'd0;
            rr_q        <= 2'd3;
            dir_q       <= 2'b00;
            duty_q      <= 12'h000;
            forced_q    <= 1'b0;
            ack_q       <= 4'h0;
            err_q       <= 4'h0;
            trip_q      <= 4'h0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            attempt_q   <= attempt_d;
            wait_q      <= wait_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            tx_stop_q   <= tx_stop_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            dir_q       <= dir_d;
            duty_q      <= duty_d;
            forced_q    <= forced_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            trip_q      <= trip_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef PCA_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wcnt_q [4];
    logic [3:0]        fired_q;

    // A saturated counter asks for one coast; fired_q blocks repeats until a good ack.
    always_comb begin
        wdog_req = 4'h0;
        for (int k = 0; k < 4; k++) begin
            wdog_req[k] = (wcnt_q[k] == WDOG_CYCLES) && !fired_q[k];
        end
    end

    // Per-motor idle counters, cleared by a successful ack of that motor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) wcnt_q[k] <= '0;
            fired_q <= 4'h0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ack_q[k] && !err_q[k]) begin
                    wcnt_q[k]  <= '0;
                    fired_q[k] <= 1'b0;
                end else begin
                    if (init_done_q && (wcnt_q[k] != WDOG_CYCLES)) wcnt_q[k] <= wcnt_q[k] + 1'b1;
                    if (force_grant[k]) fired_q[k] <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{WDOG_CYCLES, force_grant};
    assign wdog_req   = 4'h0;
`endif

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign tx_stop   = tx_stop_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign wdog_trip = trip_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pca9685_motor_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for pca9685_motor_sched: expected bytes/acks queued at stimulus time.
// An I2C master model accepts bytes (optionally with random stalls) and answers each one.
// Build with PCA_SCHED_WDOG_EN to run the watchdog scenario instead of the command scenarios.
module tb_pca9685_motor_sched;

    typedef struct { logic [7:0] dat; logic st; logic sp; } exp_t;
    typedef struct { int k; logic e; } ack_ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  cmd_dir;
    logic [47:0] cmd_duty;
    logic [3:0]  ack, err, wdog_trip;
    logic        tx_valid, tx_start, tx_stop, tx_ready;
    logic [7:0]  tx_data;
    logic        rsp_valid, rsp_nack, busy, init_done;

    exp_t    exp_q[$];
    ack_ev_t ack_q[$];
    bit      nack_map[int];
    int      req_count[4];
    int      trip_count[4];
    int      n_checks = 0, n_fails = 0;
    int      hs_count = 0, cyc = 0, last_rsp_cyc = -10;
    bit      rand_ready = 0;
    bit      resp_pending = 0, resp_nack_v = 0;
    int      resp_wait = 0;

    always #5 clk = ~clk;

    pca9685_motor_sched #(.WDOG_CYCLES(24'd100)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .ack(ack), .err(err), .tx_valid(tx_valid), .tx_data(tx_data), .tx_start(tx_start),
        .tx_stop(tx_stop), .tx_ready(tx_ready), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .busy(busy), .init_done(init_done), .wdog_trip(wdog_trip)
    );

    // Reference byte of a motor write, built from the channel words.
    function automatic logic [7:0] model_byte(int k, logic [1:0] dir, logic [11:0] d, int i);
        logic [31:0] w_on, w_off, w_en, wa, wb, we, w;
        w_on  = 32'h0010_0000;
        w_off = 32'h0000_0010;
        w_en  = (d == 12'h000) ? w_off : (d == 12'hFFF) ? w_on : {16'h0000, d[7:0], 4'h0, d[11:8]};
        case (dir)
            2'b00:   begin wa = w_off; wb = w_off; we = w_off; end
            2'b01:   begin wa = w_on;  wb = w_off; we = w_en;  end
            2'b10:   begin wa = w_off; wb = w_on;  we = w_en;  end
            default: begin wa = w_on;  wb = w_on;  we = w_on;  end
        endcase
        if (i == 0) return 8'h80;
        if (i == 1) return 8'h06 + 8'(16 * k);
        w = (i < 6) ? wa : (i < 10) ? wb : we;
        return w[31 - 8 * ((i - 2) % 4) -: 8];
    endfunction

    function automatic void push_byte(logic [7:0] d, logic st, logic sp);
        exp_t e;
        e.dat = d; e.st = st; e.sp = sp;
        exp_q.push_back(e);
    endfunction

    function automatic void push_motor(int k, logic [1:0] dir, logic [11:0] d, int n);
        for (int i = 0; i < n; i++) push_byte(model_byte(k, dir, d, i), i == 0, i == 13);
    endfunction

    function automatic void push_init();
        push_byte(8'h80, 1, 0); push_byte(8'h00, 0, 0); push_byte(8'h20, 0, 1);
        push_byte(8'h80, 1, 0); push_byte(8'h01, 0, 0); push_byte(8'h04, 0, 1);
    endfunction

    task automatic set_cmd(int k, logic [1:0] dir, logic [11:0] d);
        cmd_dir[2*k +: 2]   = dir;
        cmd_duty[12*k +: 12] = d;
    endtask

    // Master model and requesters: drive one step after each rising edge.
    initial begin
        tx_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; req = 4'h0;
        forever begin
            @(posedge clk); #1;
            rsp_valid = 1'b0; rsp_nack = 1'b0;
            if (resp_pending) begin
                if (resp_wait == 0) begin
                    rsp_valid = 1'b1; rsp_nack = resp_nack_v; resp_pending = 0;
                end else begin
                    resp_wait--;
                end
            end
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int k = 0; k < 4; k++) req[k] = (req_count[k] > 0);
        end
    end

    // Monitor: byte scoreboard, handshake rules and ack timing, sampled on falling edges.
    initial begin
        logic       prev_stall, prev_hs;
        logic [9:0] prev_bus;
        exp_t       e;
        ack_ev_t    a;
        prev_stall = 0; prev_hs = 0; prev_bus = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 0; prev_hs = 0;
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if (tx_valid !== 1'b1 || {tx_data, tx_start, tx_stop} !== prev_bus) begin
                        n_fails++;
                        $display("FAIL hold_stable: got v=%b %h/%b/%b, need v=1 %h", tx_valid, tx_data, tx_start, tx_stop, prev_bus);
                    end
                end
                if (prev_hs) begin
                    n_checks++;
                    if (tx_valid !== 1'b0) begin
                        n_fails++;
                        $display("FAIL valid_drop: tx_valid=%b after transfer, need 0", tx_valid);
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_hs    = tx_valid && tx_ready;
                prev_bus   = {tx_data, tx_start, tx_stop};
                if (tx_valid && tx_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fails++;
                        $display("FAIL unexpected_byte: got %h start=%b stop=%b, none expected", tx_data, tx_start, tx_stop);
                    end else begin
                        e = exp_q.pop_front();
                        if ({tx_data, tx_start, tx_stop} !== {e.dat, e.st, e.sp}) begin
                            n_fails++;
                            $display("FAIL byte: got %h start=%b stop=%b, need %h start=%b stop=%b", tx_data, tx_start, tx_stop, e.dat, e.st, e.sp);
                        end
                    end
                    resp_nack_v  = nack_map.exists(hs_count);
                    resp_wait    = $urandom_range(0, 2);
                    resp_pending = 1;
                    hs_count++;
                end
                if (rsp_valid) last_rsp_cyc = cyc;
                if (ack != 4'h0) begin
                    n_checks++;
                    if (cyc != last_rsp_cyc + 1 || (err & ~ack) != 4'h0) begin
                        n_fails++;
                        $display("FAIL ack_timing: ack=%b err=%b at %0d cycles after rsp, need 1", ack, err, cyc - last_rsp_cyc);
                    end
                    for (int k = 0; k < 4; k++) begin
                        if (ack[k]) begin
                            a.k = k; a.e = err[k];
                            ack_q.push_back(a);
                            if (req_count[k] > 0) req_count[k]--;
                        end
                    end
                end
                for (int k = 0; k < 4; k++) if (wdog_trip[k]) trip_count[k]++;
            end
        end
    end

    task automatic wait_acks(int n);
        int budget;
        budget = 3000;
        while (ack_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (ack_q.size() < n) begin
            n_checks++; n_fails++;
            $display("FAIL ack_timeout: got %0d acks, need %0d", ack_q.size(), n);
        end
    endtask

    task automatic check_ack(int k, logic e);
        ack_ev_t a;
        n_checks++;
        if (ack_q.size() == 0) begin
            n_fails++;
            $display("FAIL ack_event: none, need motor %0d err=%b", k, e);
        end else begin
            a = ack_q.pop_front();
            if (a.k != k || a.e !== e) begin
                n_fails++;
                $display("FAIL ack_event: got motor %0d err=%b, need motor %0d err=%b", a.k, a.e, k, e);
            end
        end
    endtask

    task automatic check_drained(string name);
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || ack_q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_drained: %0d bytes and %0d acks left, need 0 and 0", name, exp_q.size(), ack_q.size());
        end
    endtask

    task automatic test_reset();
        int rc, budget;
        rst_n = 1'b0; cmd_dir = '0; cmd_duty = '0;
        for (int k = 0; k < 4; k++) begin req_count[k] = 0; trip_count[k] = 0; end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_valid, tx_start, tx_stop, tx_data} !== 11'h000) begin
            n_fails++; $display("FAIL reset_tx: got v=%b s=%b p=%b d=%h, need all 0", tx_valid, tx_start, tx_stop, tx_data);
        end
        n_checks++;
        if ({ack, err, wdog_trip} !== 12'h000) begin
            n_fails++; $display("FAIL reset_pulses: got ack=%b err=%b trip=%b, need 0", ack, err, wdog_trip);
        end
        n_checks++;
        if (busy !== 1'b1 || init_done !== 1'b0) begin
            n_fails++; $display("FAIL reset_status: got busy=%b init_done=%b, need 1 0", busy, init_done);
        end
        push_init();
        rst_n = 1'b1;
        rc = 0; budget = 500;
        while (rc < 6 && budget > 0) begin
            @(negedge clk);
            if (rsp_valid) rc++;
            budget--;
        end
        n_checks++;
        if (rc != 6 || init_done !== 1'b0) begin
            n_fails++; $display("FAIL init_early: rsp=%0d init_done=%b at 6th rsp, need 6 and 0", rc, init_done);
        end
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || busy !== 1'b0) begin
            n_fails++; $display("FAIL init_done: got init_done=%b busy=%b, need 1 0", init_done, busy);
        end
        check_drained("init");
    endtask

    task automatic test_round_robin();
        int order[5];
        order = '{0, 1, 2, 3, 0};
        rand_ready = 1;
        for (int k = 0; k < 4; k++) set_cmd(k, 2'b01, 12'h100 + 12'(k));
        for (int i = 0; i < 5; i++) push_motor(order[i], 2'b01, 12'h100 + 12'(order[i]), 14);
        req_count[0] = 2; req_count[1] = 1; req_count[2] = 1; req_count[3] = 1;
        wait_acks(5);
        for (int i = 0; i < 5; i++) check_ack(order[i], 1'b0);
        check_drained("round_robin");
    endtask

    task automatic test_fwd_motor2();
        set_cmd(2, 2'b01, 12'h123);
        push_motor(2, 2'b01, 12'h123, 14);
        @(negedge clk);
        req_count[2] = 1;
        @(posedge clk); #2;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fails++; $display("FAIL grant_latency_early: tx_valid=%b one cycle after grant, need 0", tx_valid);
        end
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h80 || tx_start !== 1'b1) begin
            n_fails++; $display("FAIL grant_latency: got v=%b d=%h s=%b, need 1 80 1", tx_valid, tx_data, tx_start);
        end
        wait_acks(1);
        check_ack(2, 1'b0);
        check_drained("fwd_motor2");
    endtask

    task automatic test_nack();
        int base;
        set_cmd(1, 2'b11, 12'h456);
        base = hs_count;
        nack_map[base + 5] = 1;
        push_motor(1, 2'b11, 12'h456, 6);
        push_motor(1, 2'b11, 12'h456, 14);
        req_count[1] = 1;
        wait_acks(1);
        check_ack(1, 1'b0);
        check_drained("nack_retry");
        base = hs_count;
        nack_map[base] = 1; nack_map[base + 4] = 1; nack_map[base + 18] = 1;
        push_motor(1, 2'b11, 12'h456, 1);
        push_motor(1, 2'b11, 12'h456, 4);
        push_motor(1, 2'b11, 12'h456, 14);
        req_count[1] = 1;
        wait_acks(1);
        check_ack(1, 1'b1);
        check_drained("nack_fail");
    endtask

    task automatic test_duty_edges();
        int          ks[4];
        logic [1:0]  ds[4];
        logic [11:0] vs[4];
        ks = '{0, 3, 2, 1};
        ds = '{2'b01, 2'b01, 2'b10, 2'b00};
        vs = '{12'h000, 12'hFFF, 12'h7FF, 12'hABC};
        for (int i = 0; i < 4; i++) begin
            set_cmd(ks[i], ds[i], vs[i]);
            push_motor(ks[i], ds[i], vs[i], 14);
            req_count[ks[i]] = 1;
            wait_acks(1);
            check_ack(ks[i], 1'b0);
            check_drained("duty_edges");
        end
    endtask

    task automatic test_reset_mid();
        int base, budget;
        set_cmd(0, 2'b10, 12'h321);
        base = hs_count;
        push_motor(0, 2'b10, 12'h321, 14);
        req_count[0] = 1;
        budget = 500;
        while (!(tx_valid && hs_count - base >= 3) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #2 rst_n = 1'b0;
        exp_q.delete(); ack_q.delete();
        req_count[0] = 0; resp_pending = 0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) begin
            n_fails++; $display("FAIL async_reset: got v=%b busy=%b init_done=%b, need 0 1 0", tx_valid, busy, init_done);
        end
        repeat (2) @(negedge clk);
        base = hs_count;
        nack_map[base + 1] = 1;
        push_byte(8'h80, 1, 0); push_byte(8'h00, 0, 0);
        push_init();
        rst_n = 1'b1;
        budget = 500;
        while (init_done !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fails++; $display("FAIL init_retry: init_done=%b, need 1", init_done);
        end
        check_drained("reset_mid");
    endtask

    task automatic wait_trips(int k, int n);
        int budget;
        budget = 3000;
        while (trip_count[k] < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
    endtask

    task automatic test_wdog();
        for (int k = 0; k < 4; k++) push_motor(k, 2'b00, 12'h000, 14);
        wait_trips(3, 1);
        repeat (500) @(negedge clk);
        n_checks++;
        if (trip_count[0] != 1 || trip_count[3] != 1 || ack_q.size() != 0) begin
            n_fails++; $display("FAIL wdog_once: trips m0=%0d m3=%0d acks=%0d, need 1 1 0", trip_count[0], trip_count[3], ack_q.size());
        end
        check_drained("wdog_coast");
        set_cmd(3, 2'b01, 12'h010);
        push_motor(3, 2'b01, 12'h010, 14);
        req_count[3] = 1;
        wait_acks(1);
        check_ack(3, 1'b0);
        push_motor(3, 2'b00, 12'h010, 14);
        wait_trips(3, 2);
        n_checks++;
        if (trip_count[3] != 2 || trip_count[1] != 1) begin
            n_fails++; $display("FAIL wdog_rearm: trips m3=%0d m1=%0d, need 2 1", trip_count[3], trip_count[1]);
        end
        check_drained("wdog_rearm");
    endtask

    initial begin
        test_reset();
`ifdef PCA_SCHED_WDOG_EN
        test_wdog();
`else
        test_round_robin();
        test_fwd_motor2();
        test_nack();
        test_duty_edges();
        test_reset_mid();
        n_checks++;
        if (trip_count[0] + trip_count[1] + trip_count[2] + trip_count[3] != 0) begin
            n_fails++; $display("FAIL wdog_off: %0d trips, need 0", trip_count[0] + trip_count[1] + trip_count[2] + trip_count[3]);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
